// File: rtl/boot_sequencer.sv
// boot_sequencer: copies the EEPROM boot image into the MLU slice SRAMs, the MLU
// lookahead SRAM and the control microcode SRAM over the shared BOOTSTRAP bus, then
// lowers N_BOOTED.
// Optional build macro BOOT_CHECKSUM_EN: after the last region, read one extra image
// byte and check that it cancels the 8-bit sum of all written bytes. Booting then ends
// in DONE on a match and in FAIL (N_BOOTED held high) on a mismatch.
module boot_sequencer #(
  parameter int SLICE_BYTES     = 131072,
  parameter int LOOKAHEAD_BYTES = 4096,
  parameter int CONTROL_BYTES   = 4096,
  parameter int READ_WAIT       = 3,
  parameter int WE_CYCLES       = 2
) (
  input  logic        CLK,
  input  logic        N_RST,
  output logic [17:0] EEPROM_ADDR,
  output logic        EEPROM_N_OE,
  input  logic [7:0]  EEPROM_DATA,
  output logic [16:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        MLU_SLICE_N_WE,
  output logic        MLU_LOOKAHEAD_N_WE,
  output logic        CONTROL_N_WE,
  output logic        N_BOOTED
);

  typedef enum logic [1:0] {R_SLICE, R_LOOKAHEAD, R_CONTROL, R_END} region_e;

  typedef enum logic [2:0] {
    S_FETCH, S_SETUP, S_WRITE, S_HOLD, S_DONE
`ifdef BOOT_CHECKSUM_EN
    , S_VERIFY, S_FAIL
`endif
  } state_e;

  // State entered once the last region is written, with the outputs it starts with.
`ifdef BOOT_CHECKSUM_EN
  localparam state_e END_STATE  = S_VERIFY;
  localparam logic   END_OE_N   = 1'b0;
  localparam logic   END_BOOTED = 1'b1;
`else
  localparam state_e END_STATE  = S_DONE;
  localparam logic   END_OE_N   = 1'b1;
  localparam logic   END_BOOTED = 1'b0;
`endif

  function automatic logic [17:0] region_size(input region_e r);
    case (r)
      R_SLICE:     region_size = 18'(SLICE_BYTES);
      R_LOOKAHEAD: region_size = 18'(LOOKAHEAD_BYTES);
      R_CONTROL:   region_size = 18'(CONTROL_BYTES);
      default:     region_size = 18'd0;
    endcase
  endfunction

  // First non-empty region after r (R_END when none remain); empty regions are skipped.
  function automatic region_e next_region(input region_e r);
    region_e n;
    n = region_e'(2'(r) + 2'd1);
    for (int i = 0; i < 3; i++) begin
      if (n != R_END && region_size(n) == 18'd0) n = region_e'(2'(n) + 2'd1);
    end
    next_region = n;
  endfunction

  function automatic region_e first_region();
    first_region = (region_size(R_SLICE) != 18'd0) ? R_SLICE : next_region(R_SLICE);
  endfunction

  state_e      state_q;
  region_e     region_q;
  logic [17:0] offset_q;
  logic [15:0] cnt_q;
  logic [17:0] eaddr_q;
  logic        oe_n_q;
  logic [16:0] baddr_q;
  logic [7:0]  bdata_q;
  logic [2:0]  we_n_q;     // {control, lookahead, slice}, active low
  logic        n_booted_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  // Per-byte FSM: FETCH -> SETUP -> WRITE -> HOLD, walking regions, with registered outputs.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q    <= S_FETCH;
      region_q   <= R_SLICE;
      offset_q   <= '0;
      cnt_q      <= '0;
      eaddr_q    <= '0;
      oe_n_q     <= 1'b1;
      baddr_q    <= '0;
      bdata_q    <= '0;
      we_n_q     <= 3'b111;
      n_booted_q <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (oe_n_q) begin
            // First cycle after reset: OE is still at its reset value, so the read
            // window opens here; empty leading regions are skipped at the same time.
            region_q <= first_region();
            cnt_q    <= '0;
            if (first_region() == R_END) begin
              state_q    <= END_STATE;
              oe_n_q     <= END_OE_N;
              n_booted_q <= END_BOOTED;
            end else begin
              oe_n_q <= 1'b0;
            end
          end else if (cnt_q == 16'(READ_WAIT - 1)) begin
            bdata_q <= EEPROM_DATA;
            baddr_q <= offset_q[16:0];
            oe_n_q  <= 1'b1;
            state_q <= S_SETUP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SETUP: begin
          case (region_q)
            R_SLICE:     we_n_q <= 3'b110;
            R_LOOKAHEAD: we_n_q <= 3'b101;
            R_CONTROL:   we_n_q <= 3'b011;
            default:     we_n_q <= 3'b111;
          endcase
`ifdef BOOT_CHECKSUM_EN
          sum_q   <= sum_q + bdata_q;
`endif
          cnt_q   <= '0;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (cnt_q == 16'(WE_CYCLES - 1)) begin
            we_n_q  <= 3'b111;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_HOLD: begin
          eaddr_q <= eaddr_q + 18'd1;
          cnt_q   <= '0;
          if (offset_q == region_size(region_q) - 18'd1) begin
            offset_q <= '0;
            region_q <= next_region(region_q);
            if (next_region(region_q) == R_END) begin
              state_q    <= END_STATE;
              oe_n_q     <= END_OE_N;
              n_booted_q <= END_BOOTED;
            end else begin
              state_q <= S_FETCH;
              oe_n_q  <= 1'b0;
            end
          end else begin
            offset_q <= offset_q + 18'd1;
            state_q  <= S_FETCH;
            oe_n_q   <= 1'b0;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_VERIFY: begin
          if (cnt_q == 16'(READ_WAIT - 1)) begin
            oe_n_q <= 1'b1;
            if (8'(sum_q + EEPROM_DATA) == 8'd0) begin
              state_q    <= S_DONE;
              n_booted_q <= 1'b0;
            end else begin
              state_q <= S_FAIL;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        default: begin
          // DONE / FAIL: terminal until reset, all outputs hold.
        end
      endcase
    end
  end

  assign EEPROM_ADDR        = eaddr_q;
  assign EEPROM_N_OE        = oe_n_q;
  assign BOOTSTRAP_ADDR     = baddr_q;
  assign BOOTSTRAP_DATA     = bdata_q;
  assign MLU_SLICE_N_WE     = we_n_q[0];
  assign MLU_LOOKAHEAD_N_WE = we_n_q[1];
  assign CONTROL_N_WE       = we_n_q[2];
  assign N_BOOTED           = n_booted_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: scoreboard of expected SRAM writes plus per-cycle strobe rules.
module tb_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  // DUT A: 4/2/2 regions. DUT B: lookahead region empty.
  logic [17:0] a_eaddr, b_eaddr;
  logic        a_oe_n, b_oe_n;
  logic [7:0]  a_edata, b_edata;
  logic [16:0] a_baddr, b_baddr;
  logic [7:0]  a_bdata, b_bdata;
  logic        a_slice_n, a_la_n, a_ctl_n, a_nbooted;
  logic        b_slice_n, b_la_n, b_ctl_n, b_nbooted;

  logic [7:0] img_a [0:15];
  logic [7:0] img_b [0:15];
  assign a_edata = img_a[a_eaddr[3:0]];
  assign b_edata = img_b[b_eaddr[3:0]];

  boot_sequencer #(.SLICE_BYTES(4), .LOOKAHEAD_BYTES(2), .CONTROL_BYTES(2),
                   .READ_WAIT(1), .WE_CYCLES(1)) dut_a (
    .CLK(clk), .N_RST(rst_a_n), .EEPROM_ADDR(a_eaddr), .EEPROM_N_OE(a_oe_n),
    .EEPROM_DATA(a_edata), .BOOTSTRAP_ADDR(a_baddr), .BOOTSTRAP_DATA(a_bdata),
    .MLU_SLICE_N_WE(a_slice_n), .MLU_LOOKAHEAD_N_WE(a_la_n), .CONTROL_N_WE(a_ctl_n),
    .N_BOOTED(a_nbooted));

  boot_sequencer #(.SLICE_BYTES(4), .LOOKAHEAD_BYTES(0), .CONTROL_BYTES(2),
                   .READ_WAIT(1), .WE_CYCLES(1)) dut_b (
    .CLK(clk), .N_RST(rst_b_n), .EEPROM_ADDR(b_eaddr), .EEPROM_N_OE(b_oe_n),
    .EEPROM_DATA(b_edata), .BOOTSTRAP_ADDR(b_baddr), .BOOTSTRAP_DATA(b_bdata),
    .MLU_SLICE_N_WE(b_slice_n), .MLU_LOOKAHEAD_N_WE(b_la_n), .CONTROL_N_WE(b_ctl_n),
    .N_BOOTED(b_nbooted));

  typedef struct packed {
    logic [1:0]  tgt;   // 0 slice, 1 lookahead, 2 control
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write sequences, straight from the image layout A0+i.
  task automatic push_a();
    for (int i = 0; i < 4; i++) q_a.push_back('{2'd0, 17'(i), 8'(8'hA0 + i)});
    for (int i = 0; i < 2; i++) q_a.push_back('{2'd1, 17'(i), 8'(8'hA4 + i)});
    for (int i = 0; i < 2; i++) q_a.push_back('{2'd2, 17'(i), 8'(8'hA6 + i)});
  endtask

  task automatic push_b();
    for (int i = 0; i < 4; i++) q_b.push_back('{2'd0, 17'(i), 8'(8'hA0 + i)});
    for (int i = 0; i < 2; i++) q_b.push_back('{2'd2, 17'(i), 8'(8'hA4 + i)});
  endtask

  // Monitor A: scoreboard pop on each strobe fall, plus per-cycle strobe invariants.
  logic        mon_a_en = 1'b0;
  int          a_len;
  logic        a_prev_low;
  logic [24:0] a_prev_ad;
  always @(negedge clk) begin : mon_a
    int  lc;
    int  tg;
    wr_t e;
    if (!mon_a_en) begin
      a_len      = 0;
      a_prev_low = 1'b0;
      a_prev_ad  = {a_baddr, a_bdata};
    end else begin
      lc = int'(!a_slice_n) + int'(!a_la_n) + int'(!a_ctl_n);
      chk("one_strobe", 32'(lc <= 1), 32'd1);
      chk("strobe_while_oe", 32'(!a_oe_n && lc != 0), 32'd0);
      if (lc != 0 && !a_prev_low) begin
        tg = !a_slice_n ? 0 : (!a_la_n ? 1 : 2);
        if (q_a.size() == 0) begin
          chk("a_unexpected_write", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          $display("A write tgt=%0d addr=%0d data=%02h", tg, a_baddr, a_bdata);
          chk("a_wr_tgt", 32'(tg), 32'(e.tgt));
          chk("a_wr_addr", 32'(a_baddr), 32'(e.addr));
          chk("a_wr_data", 32'(a_bdata), 32'(e.data));
        end
      end
      if (lc != 0 || a_prev_low) chk("addr_data_stable", 32'({a_baddr, a_bdata}), 32'(a_prev_ad));
      if (lc != 0) a_len++;
      else if (a_prev_low) begin
        chk("strobe_len", 32'(a_len), 32'd1);
        a_len = 0;
      end
      a_prev_low = (lc != 0);
      a_prev_ad  = {a_baddr, a_bdata};
    end
  end

  // Monitor B: scoreboard only, plus watch for any lookahead strobe.
  logic mon_b_en = 1'b0;
  logic b_prev_low = 1'b0;
  logic b_la_seen = 1'b0;
  int   b_writes = 0;
  always @(negedge clk) begin : mon_b
    logic low;
    int   tg;
    wr_t  e;
    low = !b_slice_n || !b_la_n || !b_ctl_n;
    if (mon_b_en) begin
      if (!b_la_n) b_la_seen = 1'b1;
      if (low && !b_prev_low) begin
        b_writes++;
        tg = !b_slice_n ? 0 : (!b_la_n ? 1 : 2);
        if (q_b.size() == 0) begin
          chk("b_unexpected_write", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          $display("B write tgt=%0d addr=%0d data=%02h", tg, b_baddr, b_bdata);
          chk("b_wr_tgt", 32'(tg), 32'(e.tgt));
          chk("b_wr_addr", 32'(b_baddr), 32'(e.addr));
          chk("b_wr_data", 32'(b_bdata), 32'(e.data));
        end
      end
    end
    b_prev_low = low;
  end

  // Count posedges after release (at a negedge) until N_BOOTED is seen low; bounded.
  task automatic wait_booted_a(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (!a_nbooted) break;
    end
  endtask

  task automatic wait_booted_b(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (!b_nbooted) break;
    end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_nbooted"}, 32'(a_nbooted), 32'd1);
    chk({tag, "_strobes"}, 32'({a_ctl_n, a_la_n, a_slice_n}), 32'h7);
    chk({tag, "_oe"}, 32'(a_oe_n), 32'd1);
    chk({tag, "_eaddr"}, 32'(a_eaddr), 32'd0);
    chk({tag, "_baddr"}, 32'(a_baddr), 32'd0);
    chk({tag, "_bdata"}, 32'(a_bdata), 32'd0);
  endtask

  int   n;
  int   done_a;
  int   done_b;
  logic found;
  logic late;

  initial begin
    for (int i = 0; i < 16; i++) begin
      img_a[i] = 8'(8'hA0 + i);
      img_b[i] = 8'(8'hA0 + i);
    end
`ifdef BOOT_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'd0;
      for (int i = 0; i < 8; i++) s = s + img_a[i];
      img_a[8] = 8'(-s);
      s = 8'd0;
      for (int i = 0; i < 6; i++) s = s + img_b[i];
      img_b[6] = 8'(-s);
    end
    done_a = 34;   // 32 byte cycles + release cycle + one verify read
    done_b = 26;
`else
    done_a = 33;   // 8 bytes x 4 cycles + 1
    done_b = 25;   // 6 bytes x 4 cycles + 1
`endif

    // Reset values.
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");

    // Full boot of DUT A.
    push_a();
    rst_a_n  = 1'b1;
    mon_a_en = 1'b1;
    wait_booted_a(n);
    $display("A boot done after %0d cycles", n);
    chk("a_boot_cycles", 32'(n), 32'(done_a));
    chk("a_sb_empty", 32'(q_a.size()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_nbooted", 32'(a_nbooted), 32'd0);
    chk("done_oe", 32'(a_oe_n), 32'd1);
    chk("done_strobes", 32'({a_ctl_n, a_la_n, a_slice_n}), 32'h7);
    chk("done_baddr", 32'(a_baddr), 32'd1);
    chk("done_bdata", 32'(a_bdata), 32'hA7);

    // Reset during the write of lookahead byte 1.
    @(negedge clk);
    mon_a_en = 1'b0;
    rst_a_n  = 1'b0;
    @(negedge clk);
    q_a.delete();
    push_a();
    rst_a_n  = 1'b1;
    mon_a_en = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (!a_la_n && a_baddr == 17'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("la1_write_seen", 32'(found), 32'd1);
    mon_a_en = 1'b0;
    rst_a_n  = 1'b0;
    #1;
    chk("midrst_la_we", 32'(a_la_n), 32'd1);
    check_reset_a("midrst");
    @(negedge clk);
    q_a.delete();
    push_a();
    rst_a_n  = 1'b1;
    mon_a_en = 1'b1;
    wait_booted_a(n);
    $display("A reboot done after %0d cycles", n);
    chk("a_reboot_cycles", 32'(n), 32'(done_a));
    chk("a_reboot_sb_empty", 32'(q_a.size()), 32'd0);

    // Zero-size lookahead region on DUT B.
    @(negedge clk);
    push_b();
    rst_b_n  = 1'b1;
    mon_b_en = 1'b1;
    wait_booted_b(n);
    $display("B boot done after %0d cycles", n);
    chk("b_boot_cycles", 32'(n), 32'(done_b));
    chk("b_sb_empty", 32'(q_b.size()), 32'd0);
    chk("b_la_never_low", 32'(b_la_seen), 32'd0);
    chk("b_write_count", 32'(b_writes), 32'd6);

`ifdef BOOT_CHECKSUM_EN
    // Corrupted check byte: boot must stall with no further strobes.
    @(negedge clk);
    mon_a_en = 1'b0;
    rst_a_n  = 1'b0;
    img_a[8] = img_a[8] ^ 8'h01;
    @(negedge clk);
    q_a.delete();
    push_a();
    rst_a_n  = 1'b1;
    mon_a_en = 1'b1;
    late     = 1'b0;
    for (int i = 1; i <= 134; i++) begin
      @(posedge clk);
      #1;
      if (i > 34 && (!a_slice_n || !a_la_n || !a_ctl_n || !a_oe_n)) late = 1'b1;
      if (!a_nbooted) late = 1'b1;
    end
    $display("A corrupted-checksum run ended, nbooted=%0d", a_nbooted);
    chk("cksum_fail_nbooted", 32'(a_nbooted), 32'd1);
    chk("cksum_fail_quiet", 32'(late), 32'd0);
    chk("cksum_fail_sb_empty", 32'(q_a.size()), 32'd0);
    chk("cksum_fail_oe", 32'(a_oe_n), 32'd1);
`else
    late = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
